// File: rtl/tilelink_arbiter_pkg.sv
// Shared TileLink-UL payload types, opcode constants and arbiter state encoding.
package tilelink_arbiter_pkg;

  localparam int unsigned TL_AW    = 32;
  localparam int unsigned TL_DW    = 32;
  localparam int unsigned TL_SRC_W = 4;

  localparam logic [2:0] TL_A_PUT_FULL        = 3'd0;
  localparam logic [2:0] TL_A_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] TL_A_GET             = 3'd4;
  localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

  typedef struct packed {
    logic                  a_valid;
    logic [2:0]            a_opcode;
    logic [2:0]            a_param;
    logic [1:0]            a_size;
    logic [TL_SRC_W-1:0]   a_source;
    logic [TL_AW-1:0]      a_address;
    logic [TL_DW/8-1:0]    a_mask;
    logic [TL_DW-1:0]      a_data;
  } tilelink_a;

  typedef struct packed {
    logic                  d_valid;
    logic [2:0]            d_opcode;
    logic [1:0]            d_param;
    logic [1:0]            d_size;
    logic [TL_SRC_W-1:0]   d_source;
    logic                  d_sink;
    logic                  d_error;
    logic [TL_DW-1:0]      d_data;
  } tilelink_d;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/tilelink_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins; on a tie the one that did not win last wins.
module tilelink_arbiter_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant,
  output logic       winner
);

  always_comb begin
    winner = (&req) ? !last : req[1];
    grant  = 2'b00;
    if (|req) begin
      grant[winner] = 1'b1;
    end
  end

endmodule

// File: rtl/tilelink_arbiter.sv
// Two-master TileLink-UL arbiter: one outstanding transaction, round-robin grant,
// response steering by owner, and a response timeout that synthesises an error.
module tilelink_arbiter
  import tilelink_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic      clock,
  input  logic      reset_in,
  input  tilelink_a m0_tla,
  output logic      m0_a_ready,
  output tilelink_d m0_tld,
  input  tilelink_a m1_tla,
  output logic      m1_a_ready,
  output tilelink_d m1_tld,
  output tilelink_a s_tla,
  input  tilelink_d s_tld,
  output logic      busy,
  output logic      stray_resp
);

  arb_state_e          state_q, state_d;
  logic                rr_last_q, rr_last_d;
  logic                owner_q, owner_d;
  logic                get_q, get_d;
  logic                stray_q, stray_d;
  logic [TL_SRC_W-1:0] src_q, src_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [1:0] req;
  logic [1:0] grant;
  logic       winner;
  logic       resp_fire;
  logic       tmo_fire;
  logic       do_grant;
  tilelink_a  win_tla;
  tilelink_d  rsp;

  assign req = {m1_tla.a_valid, m0_tla.a_valid};

  tilelink_arbiter_rr_pick2 u_pick (
    .req    (req),
    .last   (rr_last_q),
    .grant  (grant),
    .winner (winner)
  );

  // A real response on the timeout cycle takes priority over the synthesised error.
  always_comb begin
    resp_fire = (state_q == BUSY) && s_tld.d_valid;
    tmo_fire  = (state_q == BUSY) && !s_tld.d_valid && (cnt_q == CNT_W'(TIMEOUT - 1));
    do_grant  = !reset_in && (|grant) && ((state_q == IDLE) || resp_fire);
    win_tla   = winner ? m1_tla : m0_tla;
  end

  // Combinational request forwarding and response steering.
  always_comb begin
    s_tla      = '0;
    m0_a_ready = 1'b0;
    m1_a_ready = 1'b0;
    rsp        = '0;
    m0_tld     = '0;
    m1_tld     = '0;
    if (do_grant) begin
      s_tla          = win_tla;
      s_tla.a_source = TL_SRC_W'(winner);
      s_tla.a_valid  = 1'b1;
      m0_a_ready     = !winner;
      m1_a_ready     = winner;
    end
    if (resp_fire) begin
      rsp          = s_tld;
      rsp.d_source = src_q;
    end else if (tmo_fire) begin
      rsp.d_valid  = 1'b1;
      rsp.d_error  = 1'b1;
      rsp.d_opcode = get_q ? TL_D_ACCESS_ACK_DATA : TL_D_ACCESS_ACK;
      rsp.d_source = src_q;
    end
    if (owner_q) begin
      m1_tld = rsp;
    end else begin
      m0_tld = rsp;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    owner_d   = owner_q;
    get_d     = get_q;
    src_d     = src_q;
    cnt_d     = cnt_q;
    stray_d   = stray_q;
    case (state_q)
      IDLE: begin
        if (s_tld.d_valid) begin
          stray_d = 1'b1;
        end
      end
      BUSY: begin
        if (resp_fire || tmo_fire) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Grant overrides the completion return to IDLE for back-to-back transfers.
    if (do_grant) begin
      state_d   = BUSY;
      owner_d   = winner;
      rr_last_d = winner;
      cnt_d     = '0;
      src_d     = win_tla.a_source;
      get_d     = (win_tla.a_opcode == TL_A_GET);
    end
  end

  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      owner_q   <= 1'b0;
      get_q     <= 1'b0;
      src_q     <= '0;
      cnt_q     <= '0;
      stray_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      owner_q   <= owner_d;
      get_q     <= get_d;
      src_q     <= src_d;
      cnt_q     <= cnt_d;
      stray_q   <= stray_d;
    end
  end

  assign busy       = (state_q == BUSY);
  assign stray_resp = stray_q;

endmodule

// File: tb/tb_tilelink_arbiter.sv
// Directed bench for tilelink_arbiter with a transaction-level reference model checked every cycle.
module tb_tilelink_arbiter;
  import tilelink_arbiter_pkg::*;

  localparam int unsigned TIMEOUT = 16;

  logic      clock;
  logic      reset_in;
  tilelink_a m0_tla, m1_tla, s_tla;
  tilelink_d m0_tld, m1_tld, s_tld;
  logic      m0_a_ready, m1_a_ready, busy, stray_resp;

  int          total = 0;
  int          bad   = 0;
  logic        auto_slave;
  logic [31:0] slv_data;

  tilelink_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clock      (clock),
    .reset_in   (reset_in),
    .m0_tla     (m0_tla),
    .m0_a_ready (m0_a_ready),
    .m0_tld     (m0_tld),
    .m1_tla     (m1_tla),
    .m1_a_ready (m1_a_ready),
    .m1_tld     (m1_tld),
    .s_tla      (s_tla),
    .s_tld      (s_tld),
    .busy       (busy),
    .stray_resp (stray_resp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic tilelink_a mk_a(input logic [2:0] op, input logic [3:0] src,
                                     input logic [31:0] addr, input logic [31:0] data);
    tilelink_a a;
    a           = '0;
    a.a_valid   = 1'b1;
    a.a_opcode  = op;
    a.a_size    = 2'd2;
    a.a_source  = src;
    a.a_address = addr;
    a.a_mask    = 4'hF;
    a.a_data    = data;
    return a;
  endfunction

  // One clock; an optional block_ram-like slave answers each accepted request one cycle later.
  task automatic tick();
    tilelink_a sa;
    logic      p;
    sa = s_tla;
    p  = auto_slave && sa.a_valid;
    @(posedge clock);
    #1;
    if (auto_slave) begin
      s_tld = '0;
      if (p) begin
        s_tld.d_valid  = 1'b1;
        s_tld.d_opcode = (sa.a_opcode == TL_A_GET) ? TL_D_ACCESS_ACK_DATA : TL_D_ACCESS_ACK;
        s_tld.d_size   = sa.a_size;
        s_tld.d_source = sa.a_source;
        s_tld.d_data   = (sa.a_opcode == TL_A_GET) ? slv_data : 32'h0;
      end
    end
  endtask

  // Reference model: outstanding transaction record, age since grant, and who is preferred next.
  bit                  m_busy, m_get, m_stray;
  int                  m_owner, m_age, m_prefer;
  logic [TL_SRC_W-1:0] m_src;

  always @(negedge clock) begin : model
    tilelink_a e_s;
    tilelink_d e_d0, e_d1, rsp;
    logic      e_r0, e_r1;
    int        win;
    bit        done, tmo;
    e_s = '0; e_d0 = '0; e_d1 = '0; rsp = '0; e_r0 = 1'b0; e_r1 = 1'b0;
    win = -1; done = 1'b0; tmo = 1'b0;
    if (reset_in) begin
      m_busy = 1'b0; m_get = 1'b0; m_stray = 1'b0;
      m_owner = 0; m_age = 0; m_prefer = 0; m_src = '0;
    end else begin
      done = m_busy && s_tld.d_valid;
      tmo  = m_busy && !s_tld.d_valid && (m_age == TIMEOUT);
      if (done) begin
        rsp          = s_tld;
        rsp.d_source = m_src;
      end else if (tmo) begin
        rsp.d_valid  = 1'b1;
        rsp.d_error  = 1'b1;
        rsp.d_opcode = m_get ? TL_D_ACCESS_ACK_DATA : TL_D_ACCESS_ACK;
        rsp.d_source = m_src;
      end
      if (m_owner == 0) e_d0 = rsp;
      else              e_d1 = rsp;
      if (!m_busy || done) begin
        if (m0_tla.a_valid && m1_tla.a_valid) win = m_prefer;
        else if (m0_tla.a_valid)              win = 0;
        else if (m1_tla.a_valid)              win = 1;
      end
      if (win >= 0) begin
        e_s          = (win == 1) ? m1_tla : m0_tla;
        e_s.a_source = TL_SRC_W'(win);
        e_s.a_valid  = 1'b1;
        e_r0         = (win == 0);
        e_r1         = (win == 1);
      end
    end
    chk("m_s_tla", s_tla, e_s);
    chk("m_m0_ready", m0_a_ready, e_r0);
    chk("m_m1_ready", m1_a_ready, e_r1);
    chk("m_m0_tld", m0_tld, e_d0);
    chk("m_m1_tld", m1_tld, e_d1);
    chk("m_busy", busy, m_busy);
    chk("m_stray", stray_resp, m_stray);
    if (!reset_in) begin
      if (!m_busy && s_tld.d_valid) m_stray = 1'b1;
      if (win >= 0) begin
        m_busy   = 1'b1;
        m_owner  = win;
        m_age    = 1;
        m_prefer = 1 - win;
        m_src    = (win == 1) ? m1_tla.a_source : m0_tla.a_source;
        m_get    = ((win == 1) ? m1_tla.a_opcode : m0_tla.a_opcode) == TL_A_GET;
      end else if (done || tmo) begin
        m_busy = 1'b0;
      end else if (m_busy) begin
        m_age++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_in = 1'b1; m0_tla = '0; m1_tla = '0; s_tld = '0;
    auto_slave = 1'b0; slv_data = '0;
    repeat (2) @(posedge clock);
    #1 reset_in = 1'b0;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_stray", stray_resp, 1'b0);
    chk("rst_s_valid", s_tla.a_valid, 1'b0);
    chk("rst_d0_valid", m0_tld.d_valid, 1'b0);
    tick();

    // Contention: four back-to-back grants alternate starting with m0.
    auto_slave = 1'b1; slv_data = 32'h0BAD_F00D;
    m0_tla = mk_a(TL_A_GET, 4'h3, 32'h8000_0100, 32'h0);
    m1_tla = mk_a(TL_A_GET, 4'h7, 32'h8000_0200, 32'h0);
    for (int i = 0; i < 5; i++) begin
      m0_tla.a_valid = (i < 4);
      m1_tla.a_valid = (i < 4);
      #2;
      if (i < 4) begin
        chk("cont_r0", m0_a_ready, (i % 2 == 0));
        chk("cont_r1", m1_a_ready, (i % 2 == 1));
      end
      if (i > 0) begin
        if ((i - 1) % 2 == 0) begin
          chk("cont_d0v", m0_tld.d_valid, 1'b1);
          chk("cont_d0src", m0_tld.d_source, 4'h3);
          chk("cont_d1v", m1_tld.d_valid, 1'b0);
        end else begin
          chk("cont_d1v", m1_tld.d_valid, 1'b1);
          chk("cont_d1src", m1_tld.d_source, 4'h7);
          chk("cont_d0v", m0_tld.d_valid, 1'b0);
        end
      end
      tick();
    end

    // Single read from m0 through a one-cycle slave.
    slv_data = 32'hDEAD_BEEF;
    m0_tla = mk_a(TL_A_GET, 4'h5, 32'h8000_0010, 32'h0);
    m1_tla = '0;
    #2;
    chk("rd_ready", m0_a_ready, 1'b1);
    chk("rd_addr", s_tla.a_address, 32'h8000_0010);
    chk("rd_src_ovr", s_tla.a_source, 4'h0);
    tick();
    m0_tla.a_valid = 1'b0;
    #2;
    chk("rd_d_valid", m0_tld.d_valid, 1'b1);
    chk("rd_d_data", m0_tld.d_data, 32'hDEAD_BEEF);
    chk("rd_d_src", m0_tld.d_source, 4'h5);
    chk("rd_d_op", m0_tld.d_opcode, TL_D_ACCESS_ACK_DATA);
    chk("rd_m1_quiet", m1_tld.d_valid, 1'b0);
    tick();
    #2;
    chk("rd_idle", busy, 1'b0);
    tick();

    // Real response arriving on the timeout cycle wins.
    auto_slave = 1'b0; s_tld = '0;
    m0_tla = mk_a(TL_A_GET, 4'h2, 32'h8000_0040, 32'h0);
    #2;
    chk("te_ready", m0_a_ready, 1'b1);
    tick();
    m0_tla.a_valid = 1'b0;
    for (int c = 1; c < 16; c++) begin
      #2;
      chk("te_wait", m0_tld.d_valid, 1'b0);
      tick();
    end
    s_tld          = '0;
    s_tld.d_valid  = 1'b1;
    s_tld.d_opcode = TL_D_ACCESS_ACK_DATA;
    s_tld.d_size   = 2'd2;
    s_tld.d_data   = 32'h1234_5678;
    #2;
    chk("te_d_valid", m0_tld.d_valid, 1'b1);
    chk("te_d_error", m0_tld.d_error, 1'b0);
    chk("te_d_data", m0_tld.d_data, 32'h1234_5678);
    chk("te_d_src", m0_tld.d_source, 4'h2);
    tick();
    s_tld = '0;
    #2;
    chk("te_idle", busy, 1'b0);
    chk("te_no_stray", stray_resp, 1'b0);
    tick();

    // Timeout on an m1 Put, then a stray late response.
    m1_tla = mk_a(TL_A_PUT_FULL, 4'h9, 32'h8000_0080, 32'h0000_CAFE);
    #2;
    chk("to_ready", m1_a_ready, 1'b1);
    tick();
    m1_tla.a_valid = 1'b0;
    for (int c = 1; c < 16; c++) begin
      #2;
      chk("to_wait", m1_tld.d_valid, 1'b0);
      chk("to_busy", busy, 1'b1);
      tick();
    end
    #2;
    chk("to_d_valid", m1_tld.d_valid, 1'b1);
    chk("to_d_error", m1_tld.d_error, 1'b1);
    chk("to_d_op", m1_tld.d_opcode, TL_D_ACCESS_ACK);
    chk("to_d_src", m1_tld.d_source, 4'h9);
    chk("to_d_data", m1_tld.d_data, 32'h0);
    chk("to_m0_quiet", m0_tld.d_valid, 1'b0);
    tick();
    #2;
    chk("to_idle", busy, 1'b0);
    tick();
    tick();
    s_tld         = '0;
    s_tld.d_valid = 1'b1;
    s_tld.d_data  = 32'h77;
    #2;
    chk("st_m0_drop", m0_tld.d_valid, 1'b0);
    chk("st_m1_drop", m1_tld.d_valid, 1'b0);
    tick();
    s_tld = '0;
    #2;
    chk("st_flag", stray_resp, 1'b1);
    tick();
    #2;
    chk("st_sticky", stray_resp, 1'b1);
    tick();

    // Asynchronous reset in the middle of a back-to-back handover.
    m0_tla = mk_a(TL_A_GET, 4'h1, 32'h8000_00C0, 32'h0);
    #2;
    chk("ar_grant0", m0_a_ready, 1'b1);
    tick();
    m0_tla.a_valid = 1'b0;
    m1_tla = mk_a(TL_A_GET, 4'h6, 32'h8000_00D0, 32'h0);
    s_tld          = '0;
    s_tld.d_valid  = 1'b1;
    s_tld.d_opcode = TL_D_ACCESS_ACK_DATA;
    s_tld.d_data   = 32'h55AA;
    #2;
    chk("ar_pre_d", m0_tld.d_valid, 1'b1);
    chk("ar_pre_r1", m1_a_ready, 1'b1);
    chk("ar_pre_busy", busy, 1'b1);
    reset_in = 1'b1;
    #1;
    chk("ar_busy", busy, 1'b0);
    chk("ar_r1", m1_a_ready, 1'b0);
    chk("ar_d0", m0_tld.d_valid, 1'b0);
    chk("ar_s_valid", s_tla.a_valid, 1'b0);
    chk("ar_stray_clr", stray_resp, 1'b0);
    m1_tla.a_valid = 1'b0;
    s_tld = '0;
    @(posedge clock);
    #1 reset_in = 1'b0;
    s_tld         = '0;
    s_tld.d_valid = 1'b1;
    s_tld.d_data  = 32'h99;
    #2;
    chk("ar_late_d0", m0_tld.d_valid, 1'b0);
    chk("ar_late_d1", m1_tld.d_valid, 1'b0);
    tick();
    s_tld = '0;
    #2;
    chk("ar_late_stray", stray_resp, 1'b1);
    m0_tla = mk_a(TL_A_GET, 4'h1, 32'h8000_00E0, 32'h0);
    m1_tla = mk_a(TL_A_GET, 4'h6, 32'h8000_00F0, 32'h0);
    #1;
    chk("ar_first_r0", m0_a_ready, 1'b1);
    chk("ar_first_r1", m1_a_ready, 1'b0);
    auto_slave = 1'b1;
    tick();
    m0_tla = '0;
    m1_tla = '0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tilelink_arbiter.md
Name: tilelink_arbiter

Overview:
Two-master, one-slave TileLink-UL arbiter that shares a single block_ram slave (typically data_ram) between the pinwheel_core bus port (m0) and a second requester (m1, e.g. debug/DMA loader). It allows one outstanding transaction at a time and uses round-robin grant. It steers the D response back to the owning master. A response timeout synthesises an error so that a dead slave cannot hang the core.

Parameters:
- TIMEOUT, 16: cycles in BUSY without s_tld.d_valid before an error response is synthesised; legal range 2..255.
- CNT_W, 8: width of the timeout counter; must hold TIMEOUT.

Ports:
- clock  in  1  global clock, rising edge.
- reset_in  in  1  asynchronous, active-high reset.
- m0_tla  in  tilelink_a  master 0 request channel (core).
- m0_a_ready  out  1  request from master 0 accepted this cycle.
- m0_tld  out  tilelink_d  response to master 0.
- m1_tla  in  tilelink_a  master 1 request channel.
- m1_a_ready  out  1  request from master 1 accepted this cycle.
- m1_tld  out  tilelink_d  response to master 1.
- s_tla  out  tilelink_a  request to slave.
- s_tld  in  tilelink_d  response from slave.
- busy  out  1  a transaction is outstanding.
- stray_resp  out  1  sticky flag: a slave response arrived with no transaction outstanding.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset state (asynchronous, takes effect immediately):
  - FSM goes to IDLE.
  - rr_last = 1, so m0 wins the first contest.
  - owner = 0, timeout counter = 0, stray_resp = 0.
  - All outputs are 0, including all a_valid and d_valid fields.
- States:
  - IDLE: no transaction outstanding.
  - BUSY: one transaction outstanding; owner register holds the granted master.
- Grant window: arbitration happens when the FSM is in IDLE, or in BUSY on the cycle where the response completes.
- Grant rule:
  - If only one mN_tla.a_valid is set, that master wins.
  - If both are set, the master != rr_last wins.
- Grant actions (combinational, same cycle):
  - s_tla = winner's tla, with a_source overwritten by the winner index and a_valid = 1.
  - Winner's mN_a_ready = 1.
  - Next cycle: owner <= winner, rr_last <= winner, counter <= 0, state <= BUSY.
- No grant: s_tla.a_valid = 0 and both a_ready = 0.
- BUSY, while s_tld.d_valid = 0:
  - Counter increments each cycle.
  - No new grant is made.
- BUSY, when s_tld.d_valid = 1:
  - m[owner]_tld = s_tld with d_valid = 1; the other master's d_valid = 0.
  - d_source is restored to the master's original a_source, latched at grant.
  - In the same cycle, a new grant may be issued (back-to-back). If none is issued, the next state is IDLE.
- Timeout: when the counter reaches TIMEOUT-1 with no d_valid:
  - m[owner]_tld carries d_valid = 1, d_error = 1, d_data = 0, and d_opcode = AccessAckData for a Get request or AccessAck for a Put request (opcode latched at grant).
  - Next state is IDLE; no new grant is made in that cycle.
- Response at the timeout edge: if s_tld.d_valid arrives on the timeout cycle, the real response wins and d_error passes through unchanged.
- Stray response: s_tld.d_valid in IDLE, or arriving after a timeout, is dropped, never forwarded, and sets stray_resp. stray_resp clears only on reset.
- Latency:
  - Grant is 0 cycles.
  - Response forwarding is combinational, the same cycle as s_tld.d_valid.
  - With block_ram (1-cycle response), one master alone sustains one transaction per cycle.
  - Two contending masters alternate every cycle.
- Request drop: a master that drops a_valid before being granted loses nothing; no request state is kept for ungranted masters.
- busy = (state == BUSY).
- Reset mid-transaction: the transaction is abandoned and no response is issued. A late slave response after reset sets stray_resp.

Decomposition:
- tilelink package: tilelink_a, tilelink_d and TL opcode constants (already shared).
- Add arb_state_e (IDLE, BUSY) to the same package.
- Natural sub-module rr_pick2: 2-way round-robin picker. Inputs req[1:0] and last; outputs grant[1:0] (one-hot or zero) and winner.
- Everything else lives in tilelink_arbiter.

Test Plan:
- Single read: m0 Get at 0x80000010 with a 1-cycle slave returning 0xDEADBEEF -> m0_a_ready = 1 in cycle 0. In cycle 1, m0_tld.d_valid = 1, d_data = 0xDEADBEEF, d_source equals m0's original source. m1_tld.d_valid stays 0 throughout.
- Contention: both masters hold a_valid for 4 transactions -> grants m0, m1, m0, m1 on consecutive cycles. Each response is routed to the correct master with no bubbles.
- Timeout (TIMEOUT = 16): slave never responds to an m1 Put -> exactly 16 cycles after grant, m1_tld.d_valid = 1, d_error = 1, d_opcode = AccessAck. busy drops the next cycle.
- Stray response: slave asserts d_valid 3 cycles after that timeout -> nothing is forwarded to either master and stray_resp = 1 until reset.
- Response on the timeout cycle: slave responds exactly on cycle TIMEOUT-1 -> the real data is forwarded with d_error = 0 and stray_resp stays 0.
- Async reset mid-BUSY: assert reset_in between clock edges -> busy, a_ready and d_valid drop without waiting for a clock edge. After release, the first contest is won by m0.
